multicycle_control: RTL

- Registered, multi-cycle successor to the single-cycle main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready handshakes to instruction and data memory.
- Decodes the existing 11-opcode ISA plus HALT and flags illegal opcodes.
- Adds a parametrised memory-wait timeout with a sticky error, and a global stall.
- Sits between the instruction register and the datapath; replaces the combinational decoder.

---
 rtl/multicycle_control.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: registered FETCH/DECODE/EXEC/MEM/WB control FSM with
// instruction/data memory handshakes, wait-timeout error, HALT and global stall.
module multicycle_control #(
    parameter int unsigned     OP_W    = 6,
    parameter int unsigned     TIMEOUT = 15,
    parameter int unsigned     CNT_W   = 4,
    parameter logic [OP_W-1:0] HALT_OP = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op_code,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_rd,
    output logic            ir_wrt,
    output logic            pc_wrt,
    output logic [2:0]      aluOp,
    output logic            aluSrc,
    output logic [1:0]      memToReg,
    output logic [1:0]      regWrt,
    output logic            memRd,
    output logic            memWrt,
    output logic [1:0]      Br,
    output logic            illegal,
    output logic            halted,
    output logic            err
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    typedef struct packed {
        logic       imem_rd;
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_wrt;
        logic       mem_rd;
        logic       mem_wrt;
        logic [1:0] br;
        logic       illegal;
        logic       halted;
        logic       err;
    } ctl_t;

    // Instruction class captured in DECODE, steering EXEC/MEM/WB afterwards.
    typedef struct packed {
        logic [1:0] br;
        logic [1:0] rw;
        logic       ld;
        logic       st;
    } cls_t;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctl_t             out_q, out_d;
    cls_t             cls_q, cls_d, dec_cls;
    logic [2:0]       dec_alu;
    logic             dec_src;
    logic [1:0]       dec_m2r;
    logic             dec_nop, dec_halt, dec_ill;
    logic             waiting, timed_out, keep;

    always_comb begin
        dec_alu  = '0;
        dec_src  = 1'b0;
        dec_m2r  = '0;
        dec_cls  = '0;
        dec_nop  = 1'b0;
        dec_halt = 1'b0;
        dec_ill  = 1'b0;
        if (op_code == HALT_OP) dec_halt = 1'b1;
        else case (op_code)
            OP_W'(0):  dec_nop = 1'b1;
            OP_W'(1):  begin dec_alu = 3'b001; dec_src = 1'b1; dec_cls.rw = 2'b10; end
            OP_W'(2):  begin dec_alu = 3'b010; dec_src = 1'b1; dec_cls.rw = 2'b10; end
            OP_W'(3):  begin dec_alu = 3'b011; dec_src = 1'b1; dec_cls.rw = 2'b10; end
            OP_W'(4):  dec_cls.br = 2'b01;
            OP_W'(5):  dec_cls.br = 2'b10;
            OP_W'(6):  begin dec_cls.br = 2'b11; dec_m2r = 2'b01; dec_cls.rw = 2'b01; end
            OP_W'(7):  begin dec_alu = 3'b100; dec_src = 1'b1; dec_cls.rw = 2'b10; end
            OP_W'(8):  begin dec_alu = 3'b101; dec_cls.rw = 2'b10; end
            OP_W'(9):  begin dec_alu = 3'b110; dec_cls.rw = 2'b10; end
            OP_W'(10): begin dec_alu = 3'b101; dec_m2r = 2'b10; dec_cls.rw = 2'b11; dec_cls.ld = 1'b1; end
            OP_W'(11): begin dec_alu = 3'b101; dec_cls.st = 1'b1; end
            default:   dec_ill = 1'b1;
        endcase
    end

    // FETCH only waits once a request is actually on the bus (not in the first cycle after reset).
    assign waiting   = (state_q == S_FETCH && out_q.imem_rd && !imem_ready) ||
                       (state_q == S_MEM && !dmem_ready);
    assign timed_out = waiting && (cnt_q == CNT_W'(TIMEOUT));
    assign cnt_d     = (waiting && !timed_out) ? cnt_q + 1'b1 : '0;
    assign cls_d     = (state_q == S_DECODE) ? dec_cls : cls_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = timed_out ? S_ERR : (out_q.imem_rd && imem_ready) ? S_DECODE : S_FETCH;
            S_DECODE: state_d = dec_halt ? S_HALT : (dec_nop || dec_ill) ? S_FETCH : S_EXEC;
            S_EXEC:   state_d = (cls_q.br == 2'b01 || cls_q.br == 2'b10) ? S_FETCH :
                                (cls_q.ld || cls_q.st) ? S_MEM : S_WB;
            S_MEM:    state_d = timed_out ? S_ERR : !dmem_ready ? S_MEM : cls_q.ld ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = (state_q == S_HALT) ? S_HALT : S_ERR;
        endcase
    end

    assign keep = !(state_d == S_HALT || state_d == S_ERR);

    always_comb begin
        out_d            = '0;
        out_d.imem_rd    = state_d == S_FETCH;
        out_d.alu_op     = !keep ? '0 : (state_q == S_DECODE) ? dec_alu : out_q.alu_op;
        out_d.alu_src    = keep && ((state_q == S_DECODE) ? dec_src : out_q.alu_src);
        out_d.mem_to_reg = !keep ? '0 : (state_q == S_DECODE) ? dec_m2r : out_q.mem_to_reg;
        out_d.reg_wrt    = (state_d == S_WB) ? cls_d.rw : '0;
        out_d.mem_rd     = (state_d == S_MEM) && cls_d.ld;
        out_d.mem_wrt    = (state_d == S_MEM) && cls_d.st;
        out_d.br         = (state_d == S_EXEC) ? cls_d.br : '0;
        out_d.illegal    = (state_q == S_DECODE) && dec_ill;
        out_d.halted     = state_d == S_HALT;
        out_d.err        = state_d == S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            out_q   <= '0;
            cls_q   <= '0;
        end else if (!stall) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            cls_q   <= cls_d;
        end
    end

    assign ir_wrt   = state_q == S_FETCH && out_q.imem_rd && imem_ready && !stall;
    assign pc_wrt   = ir_wrt;
    assign imem_rd  = out_q.imem_rd;
    assign aluOp    = out_q.alu_op;
    assign aluSrc   = out_q.alu_src;
    assign memToReg = out_q.mem_to_reg;
    assign regWrt   = out_q.reg_wrt;
    assign memRd    = out_q.mem_rd;
    assign memWrt   = out_q.mem_wrt;
    assign Br       = out_q.br;
    assign illegal  = out_q.illegal;
    assign halted   = out_q.halted;
    assign err      = out_q.err;
endmodule
